// File: rtl/axi_node_pkg.sv
// Shared AXI node definitions: fixed AXI attribute widths and the AW allocator state encoding.
package axi_node_pkg;

    localparam int AXI_LEN_W    = 8;
    localparam int AXI_SIZE_W   = 3;
    localparam int AXI_BURST_W  = 2;
    localparam int AXI_CACHE_W  = 4;
    localparam int AXI_PROT_W   = 3;
    localparam int AXI_REGION_W = 4;
    localparam int AXI_QOS_W    = 4;

    typedef enum logic [0:0] {
        AW_IDLE   = 1'b0,
        AW_LOCKED = 1'b1
    } aw_state_e;

endpackage

// File: rtl/axi_aw_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping modulo N.
module axi_aw_rr_arbiter #(
    parameter int N     = 7,
    parameter int LOG_N = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [LOG_N-1:0] ptr_i,
    output logic             valid_o,
    output logic [LOG_N-1:0] idx_o,
    output logic [N-1:0]     onehot_o
);

    always_comb begin
        int               c;
        logic [LOG_N-1:0] cand;
        valid_o = 1'b0;
        idx_o   = '0;
        c       = 0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            // Wrap explicitly so non-power-of-2 N never yields an index >= N.
            c = int'(ptr_i) + i;
            if (c >= N) begin
                c = c - N;
            end
            cand = LOG_N'(c);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
        onehot_o = valid_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/axi_aw_allocator.sv
// AW allocator for one master port: round-robin among slave ports, ID extension by source
// index, and a routing-tag push into the write-data ID FIFO on every accepted beat.
module axi_aw_allocator
    import axi_node_pkg::*;
#(
    parameter int AXI_ADDR_W  = 32,
    parameter int AXI_ID_IN   = 4,
    parameter int AXI_USER_W  = 6,
    parameter int N_TARG_PORT = 7,
    parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
    parameter int AXI_ID_OUT  = AXI_ID_IN + LOG_N_TARG
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [N_TARG_PORT-1:0][AXI_ID_IN-1:0]     awid_i,
    input  logic [N_TARG_PORT-1:0][AXI_ADDR_W-1:0]    awaddr_i,
    input  logic [N_TARG_PORT-1:0][AXI_LEN_W-1:0]     awlen_i,
    input  logic [N_TARG_PORT-1:0][AXI_SIZE_W-1:0]    awsize_i,
    input  logic [N_TARG_PORT-1:0][AXI_BURST_W-1:0]   awburst_i,
    input  logic [N_TARG_PORT-1:0]                    awlock_i,
    input  logic [N_TARG_PORT-1:0][AXI_CACHE_W-1:0]   awcache_i,
    input  logic [N_TARG_PORT-1:0][AXI_PROT_W-1:0]    awprot_i,
    input  logic [N_TARG_PORT-1:0][AXI_REGION_W-1:0]  awregion_i,
    input  logic [N_TARG_PORT-1:0][AXI_QOS_W-1:0]     awqos_i,
    input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]    awuser_i,
    input  logic [N_TARG_PORT-1:0]                    awvalid_i,
    output logic [N_TARG_PORT-1:0]                    awready_o,
    output logic [AXI_ID_OUT-1:0]                     awid_o,
    output logic [AXI_ADDR_W-1:0]                     awaddr_o,
    output logic [AXI_LEN_W-1:0]                      awlen_o,
    output logic [AXI_SIZE_W-1:0]                     awsize_o,
    output logic [AXI_BURST_W-1:0]                    awburst_o,
    output logic                                      awlock_o,
    output logic [AXI_CACHE_W-1:0]                    awcache_o,
    output logic [AXI_PROT_W-1:0]                     awprot_o,
    output logic [AXI_REGION_W-1:0]                   awregion_o,
    output logic [AXI_QOS_W-1:0]                      awqos_o,
    output logic [AXI_USER_W-1:0]                     awuser_o,
    output logic                                      awvalid_o,
    input  logic                                      awready_i,
    output logic                                      push_ID_o,
    output logic [LOG_N_TARG+N_TARG_PORT-1:0]         ID_o,
    input  logic                                      grant_FIFO_ID_i,
    output logic                                      dbg_state_o
);

    aw_state_e               state_q, state_d;
    logic [LOG_N_TARG-1:0]   sel_q, sel_d;
    logic [LOG_N_TARG-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LOG_N_TARG-1:0]   sel;
    logic [N_TARG_PORT-1:0]  sel_oh;
    logic                    arb_valid;
    logic [LOG_N_TARG-1:0]   arb_idx;
    logic [N_TARG_PORT-1:0]  arb_oh;
    logic                    hs;

    axi_aw_rr_arbiter #(
        .N     (N_TARG_PORT),
        .LOG_N (LOG_N_TARG)
    ) u_arb (
        .req_i    (awvalid_i),
        .ptr_i    (rr_ptr_q),
        .valid_o  (arb_valid),
        .idx_o    (arb_idx),
        .onehot_o (arb_oh)
    );

    // Handshake: a beat transfers in any cycle where awvalid_o and awready_i are both high;
    // once awvalid_o rises it stays high (LOCKED) until that transfer, and awvalid_o never
    // depends on awready_i.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;

        sel       = (state_q == AW_LOCKED) ? sel_q : arb_idx;
        sel_oh    = (state_q == AW_LOCKED) ? (N_TARG_PORT'(1) << sel_q) : arb_oh;
        awvalid_o = !rst && ((state_q == AW_LOCKED) || (grant_FIFO_ID_i && arb_valid));
        hs        = awvalid_o && awready_i;
        awready_o = hs ? sel_oh : '0;
        push_ID_o = hs;
        ID_o      = {sel, sel_oh};

        if (hs) begin
            rr_ptr_d = (sel == LOG_N_TARG'(N_TARG_PORT - 1)) ? '0 : sel + 1'b1;
            state_d  = AW_IDLE;
        end else if (awvalid_o && (state_q == AW_IDLE)) begin
            // The FIFO grant only matters here; once locked, no other pusher can fill it.
            state_d = AW_LOCKED;
            sel_d   = arb_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= AW_IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign awid_o      = {sel, awid_i[sel]};
    assign awaddr_o    = awaddr_i[sel];
    assign awlen_o     = awlen_i[sel];
    assign awsize_o    = awsize_i[sel];
    assign awburst_o   = awburst_i[sel];
    assign awlock_o    = awlock_i[sel];
    assign awcache_o   = awcache_i[sel];
    assign awprot_o    = awprot_i[sel];
    assign awregion_o  = awregion_i[sel];
    assign awqos_o     = awqos_i[sel];
    assign awuser_o    = awuser_i[sel];
    assign dbg_state_o = (state_q == AW_LOCKED);

endmodule

// File: tb/tb_axi_aw_allocator.sv
// Bench for axi_aw_allocator: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a queue-based round-robin reference model.
module tb_axi_aw_allocator;

  localparam int N    = 4;
  localparam int LOG  = 2;
  localparam int IDW  = 4;
  localparam int AW   = 32;
  localparam int UW   = 6;
  localparam int IDO  = IDW + LOG;
  localparam int TAGW = LOG + N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N-1:0][IDW-1:0] awid_i;
  logic [N-1:0][AW-1:0]  awaddr_i;
  logic [N-1:0][7:0]     awlen_i;
  logic [N-1:0][2:0]     awsize_i;
  logic [N-1:0][1:0]     awburst_i;
  logic [N-1:0]          awlock_i;
  logic [N-1:0][3:0]     awcache_i;
  logic [N-1:0][2:0]     awprot_i;
  logic [N-1:0][3:0]     awregion_i;
  logic [N-1:0][3:0]     awqos_i;
  logic [N-1:0][UW-1:0]  awuser_i;
  logic [N-1:0]          awvalid_i;
  logic [N-1:0]          awready_o;
  logic [IDO-1:0]        awid_o;
  logic [AW-1:0]         awaddr_o;
  logic [7:0]            awlen_o;
  logic [2:0]            awsize_o;
  logic [1:0]            awburst_o;
  logic                  awlock_o;
  logic [3:0]            awcache_o;
  logic [2:0]            awprot_o;
  logic [3:0]            awregion_o;
  logic [3:0]            awqos_o;
  logic [UW-1:0]         awuser_o;
  logic                  awvalid_o;
  logic                  awready_i;
  logic                  push_ID_o;
  logic [TAGW-1:0]       ID_o;
  logic                  grant;
  logic                  dbg_state_o;

  axi_aw_allocator #(
    .AXI_ADDR_W  (AW),
    .AXI_ID_IN   (IDW),
    .AXI_USER_W  (UW),
    .N_TARG_PORT (N)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .awid_i          (awid_i),
    .awaddr_i        (awaddr_i),
    .awlen_i         (awlen_i),
    .awsize_i        (awsize_i),
    .awburst_i       (awburst_i),
    .awlock_i        (awlock_i),
    .awcache_i       (awcache_i),
    .awprot_i        (awprot_i),
    .awregion_i      (awregion_i),
    .awqos_i         (awqos_i),
    .awuser_i        (awuser_i),
    .awvalid_i       (awvalid_i),
    .awready_o       (awready_o),
    .awid_o          (awid_o),
    .awaddr_o        (awaddr_o),
    .awlen_o         (awlen_o),
    .awsize_o        (awsize_o),
    .awburst_o       (awburst_o),
    .awlock_o        (awlock_o),
    .awcache_o       (awcache_o),
    .awprot_o        (awprot_o),
    .awregion_o      (awregion_o),
    .awqos_o         (awqos_o),
    .awuser_o        (awuser_o),
    .awvalid_o       (awvalid_o),
    .awready_i       (awready_i),
    .push_ID_o       (push_ID_o),
    .ID_o            (ID_o),
    .grant_FIFO_ID_i (grant),
    .dbg_state_o     (dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [TAGW-1:0] exp_q[$];
  int waits[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: first requester scanning upward from ptr, modulo N.
  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic new_beat(input int p);
    awid_i[p]     = IDW'($urandom);
    awaddr_i[p]   = $urandom;
    awlen_i[p]    = 8'($urandom);
    awsize_i[p]   = 3'($urandom);
    awburst_i[p]  = 2'($urandom);
    awlock_i[p]   = 1'($urandom);
    awcache_i[p]  = 4'($urandom);
    awprot_i[p]   = 3'($urandom);
    awregion_i[p] = 4'($urandom);
    awqos_i[p]    = 4'($urandom);
    awuser_i[p]   = UW'($urandom);
  endtask

  task automatic drive(input logic [N-1:0] v, input logic rdy, input logic g);
    awvalid_i = v;
    awready_i = rdy;
    grant     = g;
  endtask

  // ---------------- model + compare process ----------------
  initial begin : compare
    int  ptr;
    int  lport;
    int  win;
    bit  locked;
    bit  exp_v;
    bit  hs;
    ptr    = 0;
    lport  = 0;
    locked = 0;
    for (int p = 0; p < N; p++) waits[p] = 0;
    forever begin
      @(negedge clk);
      win   = -1;
      exp_v = 0;
      if (!rst) begin
        if (locked) begin
          win   = lport;
          exp_v = 1;
        end else if (grant) begin
          win   = pick(awvalid_i, ptr);
          exp_v = (win >= 0);
        end
      end
      hs = exp_v && awready_i;

      chk("awvalid_o", 64'(awvalid_o), 64'(exp_v));
      chk("awready_o", 64'(awready_o), hs ? (64'd1 << win) : 64'd0);
      chk("push_ID_o", 64'(push_ID_o), 64'(hs));
      if (!rst) chk("locked_state", 64'(dbg_state_o), 64'(locked));
      if (exp_v) begin
        chk("awid_o", 64'(awid_o), (64'(win) << IDW) | 64'(awid_i[win]));
        chk("awaddr_o", 64'(awaddr_o), 64'(awaddr_i[win]));
        chk("awattr_o",
            64'({awlen_o, awsize_o, awburst_o, awlock_o, awcache_o, awprot_o, awregion_o, awqos_o}),
            64'({awlen_i[win], awsize_i[win], awburst_i[win], awlock_i[win], awcache_i[win],
                 awprot_i[win], awregion_i[win], awqos_i[win]}));
        chk("awuser_o", 64'(awuser_o), 64'(awuser_i[win]));
      end
      if (hs) begin
        exp_q.push_back(TAGW'((win << N) | (1 << win)));
        chk("fairness_wait", 64'(waits[win] < N), 64'd1);
      end
      if (push_ID_o === 1'b1) begin
        chk("push_matches_model", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) chk("ID_o", 64'(ID_o), 64'(exp_q.pop_front()));
      end
      exp_q.delete();

      for (int p = 0; p < N; p++) begin
        if (rst || !awvalid_i[p] || (hs && win == p)) waits[p] = 0;
        else if (hs) waits[p]++;
      end

      @(posedge clk);
      if (rst) begin
        ptr    = 0;
        locked = 0;
        lport  = 0;
      end else if (hs) begin
        ptr    = (win + 1) % N;
        locked = 0;
      end else if (exp_v && !locked) begin
        locked = 1;
        lport  = win;
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  logic [TAGW-1:0] t1_id[5];
  logic [AW-1:0]   a2;
  logic [N-1:0]    acc;

  initial begin : stim
    t1_id[0] = 6'b00_0001;
    t1_id[1] = 6'b01_0010;
    t1_id[2] = 6'b10_0100;
    t1_id[3] = 6'b11_1000;
    t1_id[4] = 6'b00_0001;
    rst = 1'b1;
    drive('0, 1'b0, 1'b0);
    for (int p = 0; p < N; p++) new_beat(p);

    // Reset holds outputs low even with every port requesting.
    next();
    drive(4'b1111, 1'b1, 1'b1);
    @(negedge clk);
    chk("rst_awvalid", 64'(awvalid_o), 64'd0);
    chk("rst_awready", 64'(awready_o), 64'd0);
    chk("rst_push", 64'(push_ID_o), 64'd0);
    chk("rst_state", 64'(dbg_state_o), 64'd0);

    // All ports requesting, slave always ready: winners 0,1,2,3,0.
    next();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t1_push", 64'(push_ID_o), 64'd1);
      chk("t1_awready", 64'(awready_o), 64'(4'b0001 << (k % 4)));
      chk("t1_ID", 64'(ID_o), 64'(t1_id[k]));
      next();
    end

    // Port 2 alone, slave stalls three cycles.
    awid_i[2] = 4'hA;
    a2 = awaddr_i[2];
    drive(4'b0100, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) awready_i = 1'b1;
      @(negedge clk);
      chk("t2_awvalid", 64'(awvalid_o), 64'd1);
      chk("t2_awid", 64'(awid_o), 64'h2A);
      chk("t2_awaddr", 64'(awaddr_o), 64'(a2));
      chk("t2_push", 64'(push_ID_o), 64'(k == 3));
      if (k == 3) chk("t2_ID", 64'(ID_o), 64'(6'b10_0100));
      next();
    end

    // FIFO full: nothing issues; grant release picks port 3 (pointer after port 2).
    drive(4'b1111, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t3_awvalid", 64'(awvalid_o), 64'd0);
      chk("t3_awready", 64'(awready_o), 64'd0);
      chk("t3_push", 64'(push_ID_o), 64'd0);
      next();
    end
    grant = 1'b1;
    @(negedge clk);
    chk("t3_release_ID", 64'(ID_o), 64'(6'b11_1000));
    chk("t3_release_awready", 64'(awready_o), 64'(4'b1000));
    next();

    // Lock on port 1, then drop the FIFO grant: valid must hold.
    drive(4'b0010, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_awvalid_idle", 64'(awvalid_o), 64'd1);
    next();
    grant = 1'b0;
    @(negedge clk);
    chk("t4_awvalid_locked", 64'(awvalid_o), 64'd1);
    chk("t4_state_locked", 64'(dbg_state_o), 64'd1);
    next();
    awready_i = 1'b1;
    @(negedge clk);
    chk("t4_push", 64'(push_ID_o), 64'd1);
    chk("t4_ID", 64'(ID_o), 64'(6'b01_0010));
    next();

    // Wrap: advance pointer to 3 via port 2, then 4'b1001 yields port 3 then port 0.
    drive(4'b0100, 1'b1, 1'b1);
    @(negedge clk);
    chk("t5_ID_p2", 64'(ID_o), 64'(6'b10_0100));
    next();
    drive(4'b1001, 1'b1, 1'b1);
    @(negedge clk);
    chk("t5_ID_p3", 64'(ID_o), 64'(6'b11_1000));
    next();
    @(negedge clk);
    chk("t5_ID_p0", 64'(ID_o), 64'(6'b00_0001));
    next();

    // Reset asserted mid-cycle while locked on port 2.
    drive(4'b0100, 1'b0, 1'b1);
    @(negedge clk);
    chk("t6_awvalid_pre", 64'(awvalid_o), 64'd1);
    next();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_awvalid", 64'(awvalid_o), 64'd0);
    chk("t6_async_awready", 64'(awready_o), 64'd0);
    chk("t6_async_push", 64'(push_ID_o), 64'd0);
    chk("t6_async_state", 64'(dbg_state_o), 64'd0);
    next();
    rst = 1'b0;
    chk("t6_post_state", 64'(dbg_state_o), 64'd0);
    drive(4'b1111, 1'b1, 1'b1);
    @(negedge clk);
    chk("t6_post_ID", 64'(ID_o), 64'(6'b00_0001));
    next();

    // Randomized traffic; ports hold valid and payload until accepted.
    drive('0, 1'b0, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = awready_o;
      next();
      if (c == 1500) rst = 1'b1;
      if (c == 1503) rst = 1'b0;
      for (int p = 0; p < N; p++) begin
        if (awvalid_i[p] && acc[p]) awvalid_i[p] = 1'b0;
        if (!awvalid_i[p] && ($urandom_range(0, 99) < 45)) begin
          new_beat(p);
          awvalid_i[p] = 1'b1;
        end
      end
      awready_i = ($urandom_range(0, 3) != 0);
      grant     = ($urandom_range(0, 4) != 0);
    end

    drive('0, 1'b0, 1'b0);
    next();
    next();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
